// File: rtl/dffram_pkg.sv
// dffram_pkg: definitions shared by the DFFRAM family.
//   BYTE_W        width of one write-enable lane
//   lane_count()  number of byte lanes in a word of a given width
//   fill_state_e  state of the post-reset zero-fill sequencer
package dffram_pkg;

    localparam int BYTE_W = 8;

    function automatic int lane_count(input int width);
        return width / BYTE_W;
    endfunction

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } fill_state_e;

endpackage

// File: rtl/dffram_clear_seq.sv
// dffram_clear_seq: post-reset zero-fill sequencer.
// After reset it walks the fill address from 0 to 2**A_WIDTH-1, strobing
// one zero write per cycle. It then settles in RUN and raises ready until
// the next reset. A reset in the middle of the walk restarts it from 0.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   ready      out  array usable (registered)
//   fill_addr  out  word being cleared this cycle
//   fill_we    out  zero-write strobe for fill_addr
// Handshake: none. The sequencer runs freely and never waits on the RAM.
module dffram_clear_seq
    import dffram_pkg::*;
#(
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ready,
    output logic [A_WIDTH-1:0] fill_addr,
    output logic               fill_we
);

    localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

    fill_state_e        state_q, state_d;
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                // The last word is written on this edge, so the array is
                // fully cleared exactly when ready rises.
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign fill_addr = cnt_q;
    assign fill_we   = (state_q == CLEAR);

endmodule

// File: rtl/dffram_2p.sv
// dffram_2p: two-port flip-flop RAM.
// Port 0 reads and writes with byte-lane enables (read-before-write).
// Port 1 is read-only and forwards a same-cycle port 0 write to the same
// address. An optional output stage adds one cycle of read latency. With
// INIT_ZERO the array is cleared after reset and READY stays low until the
// clear is complete.
//   CLK     in   clock
//   RESETn  in   asynchronous active-low reset
//   READY   out  array usable
//   EN0     in   port 0 enable
//   WE0     in   port 0 byte-lane write enables
//   A0      in   port 0 address
//   Di0     in   port 0 write data
//   Do0     out  port 0 read data (0 when not enabled)
//   EN1     in   port 1 enable
//   A1      in   port 1 address
//   Do1     out  port 1 read data (0 when not enabled)
// Handshake: none. An enabled access always completes after a fixed latency
// of 1 cycle (OUT_REG = 0) or 2 cycles (OUT_REG = 1), with no back-pressure.
module dffram_2p
    import dffram_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int A_WIDTH   = 8,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    output logic                     READY,
    input  logic                     EN0,
    input  logic [WIDTH/BYTE_W-1:0]  WE0,
    input  logic [A_WIDTH-1:0]       A0,
    input  logic [WIDTH-1:0]         Di0,
    output logic [WIDTH-1:0]         Do0,
    input  logic                     EN1,
    input  logic [A_WIDTH-1:0]       A1,
    output logic [WIDTH-1:0]         Do1
);

    localparam int NUM_WORDS = 2 ** A_WIDTH;
    localparam int LANES     = lane_count(WIDTH);

    logic [WIDTH-1:0]   mem_q [NUM_WORDS];

    logic               ready;
    logic               fill_we;
    logic [A_WIDTH-1:0] fill_addr;

    generate
        if (INIT_ZERO != 0) begin : g_clear
            dffram_clear_seq #(
                .A_WIDTH (A_WIDTH)
            ) u_clear_seq (
                .clk       (CLK),
                .rst_n     (RESETn),
                .ready     (ready),
                .fill_addr (fill_addr),
                .fill_we   (fill_we)
            );
        end else begin : g_no_clear
            assign ready     = 1'b1;
            assign fill_we   = 1'b0;
            assign fill_addr = '0;
        end
    endgenerate

    assign READY = ready;

    // Port 0 lane merge: the word as it will read after this cycle's write.
    logic [WIDTH-1:0] rd0, rd1, merged0;
    logic             wr_any0;

    assign rd0     = mem_q[A0];
    assign rd1     = mem_q[A1];
    assign wr_any0 = |WE0;

    always_comb begin
        merged0 = rd0;
        for (int i = 0; i < LANES; i++) begin
            if (WE0[i]) begin
                merged0[i*BYTE_W +: BYTE_W] = Di0[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Write arbitration and first output stage.
    logic [WIDTH-1:0]   do0_q, do0_d;
    logic [WIDTH-1:0]   do1_q, do1_d;
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]   wr_data;

    always_comb begin
        do0_d   = '0;
        do1_d   = '0;
        wr_en   = 1'b0;
        wr_addr = fill_addr;
        wr_data = '0;
        if (!ready) begin
            // Only the zero-fill writes while not ready; user ports are ignored.
            wr_en = fill_we;
        end else begin
            if (EN0) begin
                do0_d = rd0;
                if (wr_any0) begin
                    wr_en   = 1'b1;
                    wr_addr = A0;
                    wr_data = merged0;
                end
            end
            if (EN1) begin
                // merged0 is built from rd0, which is the same word when A0 == A1.
                if (EN0 && wr_any0 && (A0 == A1)) begin
                    do1_d = merged0;
                end else begin
                    do1_d = rd1;
                end
            end
        end
    end

    // The array itself is not reset; the zero-fill takes care of contents.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            do0_q <= '0;
            do1_q <= '0;
        end else begin
            do0_q <= do0_d;
            do1_q <= do1_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] do0_p_q, do1_p_q;

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    do0_p_q <= '0;
                    do1_p_q <= '0;
                end else begin
                    do0_p_q <= do0_q;
                    do1_p_q <= do1_q;
                end
            end

            assign Do0 = do0_p_q;
            assign Do1 = do1_p_q;
        end else begin : g_no_out_reg
            assign Do0 = do0_q;
            assign Do1 = do1_q;
        end
    endgenerate

endmodule

// File: tb/tb_dffram_2p.sv
// tb_dffram_2p: bench for dffram_2p. Two instances with 16 words, 32-bit
// words and zero-fill share one set of inputs: dut_a without the output
// register and dut_b with it. Every issued cycle pushes its expected
// {Do0, Do1} onto one queue per instance. A monitor pops each queue at the
// matching latency and compares the result.
module tb_dffram_2p;

    logic        CLK;
    logic        RESETn;
    logic        EN0;
    logic [3:0]  WE0;
    logic [3:0]  A0;
    logic [31:0] Di0;
    logic        EN1;
    logic [3:0]  A1;

    logic        ready_a, ready_b;
    logic [31:0] do0_a, do1_a, do0_b, do1_b;

    dffram_2p #(.WIDTH(32), .A_WIDTH(4), .OUT_REG(0), .INIT_ZERO(1)) dut_a (
        .CLK(CLK), .RESETn(RESETn), .READY(ready_a),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_a),
        .EN1(EN1), .A1(A1), .Do1(do1_a)
    );

    dffram_2p #(.WIDTH(32), .A_WIDTH(4), .OUT_REG(1), .INIT_ZERO(1)) dut_b (
        .CLK(CLK), .RESETn(RESETn), .READY(ready_b),
        .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_b),
        .EN1(EN1), .A1(A1), .Do1(do1_b)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        issue_v = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    logic [63:0] item_a, item_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= issue_v;
            v2 <= v1;
        end
    end

    always @(negedge CLK) begin
        if (v1) begin
            if (exp_a_q.size() == 0) begin
                check("a_underflow", 32'd1, 32'd0);
            end else begin
                item_a = exp_a_q.pop_front();
                check("a_do0", do0_a, item_a[63:32]);
                check("a_do1", do1_a, item_a[31:0]);
            end
        end
        if (v2) begin
            if (exp_b_q.size() == 0) begin
                check("b_underflow", 32'd1, 32'd0);
            end else begin
                item_b = exp_b_q.pop_front();
                check("b_do0", do0_b, item_b[63:32]);
                check("b_do1", do1_b, item_b[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en0, input logic [3:0] we, input logic [3:0] a0,
                         input logic [31:0] di, input logic en1, input logic [3:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
        EN0 = en0; WE0 = we; A0 = a0; Di0 = di; EN1 = en1; A1 = a1;
        issue_v = 1'b1;
        exp_a_q.push_back({e0, e1});
        exp_b_q.push_back({e0, e1});
    endtask

    task automatic issue(input logic en0, input logic [3:0] we, input logic [3:0] a0,
                         input logic [31:0] di, input logic en1, input logic [3:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1);
        @(negedge CLK);
        drive(en0, we, a0, di, en1, a1, e0, e1);
    endtask

    task automatic drive_idle();
        EN0 = 1'b0; WE0 = 4'h0; A0 = 4'h0; Di0 = 32'h0; EN1 = 1'b0; A1 = 4'h0;
        issue_v = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            drive_idle();
        end
    endtask

    // Release reset and hold both ports busy with writes during the fill:
    // outputs must stay 0, and READY must rise on exactly the 16th edge.
    task automatic run_fill();
        @(negedge CLK);
        RESETn = 1'b1;
        drive(1'b1, 4'hF, 4'h0, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'h0, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            check("ready_a_fill", 32'(ready_a), 32'(k == 16));
            check("ready_b_fill", 32'(ready_b), 32'(k == 16));
            if (k < 16) begin
                drive(1'b1, 4'hF, 4'(k), 32'hFFFF_FFFF, 1'b1, 4'(15 - k), 32'h0, 32'h0);
            end else begin
                drive_idle();
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESETn = 1'b0;
        drive_idle();
        #3;
        check("rst_do0_a", do0_a, 32'h0);
        check("rst_do1_a", do1_a, 32'h0);
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_do0_b", do0_b, 32'h0);
        check("rst_do1_b", do1_b, 32'h0);
        check("rst_ready_b", 32'(ready_b), 32'h0);
        idle(2);

        run_fill();

        // every word cleared
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'h0, 4'(i), 32'h1234_5678, 1'b1, 4'(15 - i), 32'h0, 32'h0);
        end

        // byte-lane writes with read-before-write
        issue(1'b1, 4'hF, 4'd5, 32'hAABB_CCDD, 1'b0, 4'd0, 32'h0, 32'h0);
        issue(1'b1, 4'b0101, 4'd5, 32'h1122_3344, 1'b0, 4'd0, 32'hAABB_CCDD, 32'h0);
        issue(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);

        // same-address forwarding to port 1
        issue(1'b1, 4'b0011, 4'd9, 32'hDEAD_BEEF, 1'b1, 4'd9, 32'h0, 32'h0000_BEEF);
        issue(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'd9, 32'h0000_BEEF, 32'h0000_BEEF);

        // disable: outputs 0 and no write even with WE0 set
        issue(1'b0, 4'hF, 4'd5, 32'hFFFF_FFFF, 1'b0, 4'd5, 32'h0, 32'h0);
        issue(1'b1, 4'h0, 4'd5, 32'h0, 1'b1, 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
        issue(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 32'h0);

        // stream: write 0..7, then read back-to-back
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 4'hF, 4'(i), 32'hC0DE_0000 | 32'(i), 1'b0, 4'd0,
                  (i == 5) ? 32'hAA22_CC44 : 32'h0, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 4'h0, 4'(7 - i), 32'h0, 1'b1, 4'(i),
                  32'hC0DE_0000 | 32'(7 - i), 32'hC0DE_0000 | 32'(i));
        end
        idle(3);

        // asynchronous reset from RUN with live outputs
        @(negedge CLK);
        EN0 = 1'b1; A0 = 4'd5; EN1 = 1'b1; A1 = 4'd2; WE0 = 4'h0;
        repeat (3) @(negedge CLK);
        check("live_do0_a", do0_a, 32'hC0DE_0005);
        check("live_do1_a", do1_a, 32'hC0DE_0002);
        check("live_do0_b", do0_b, 32'hC0DE_0005);
        check("live_do1_b", do1_b, 32'hC0DE_0002);
        RESETn = 1'b0;
        #1;
        check("arst_do0_a", do0_a, 32'h0);
        check("arst_do1_a", do1_a, 32'h0);
        check("arst_do0_b", do0_b, 32'h0);
        check("arst_do1_b", do1_b, 32'h0);
        check("arst_ready_a", 32'(ready_a), 32'h0);
        check("arst_ready_b", 32'(ready_b), 32'h0);
        drive_idle();

        // partial fill, then reset at fill address 7
        @(negedge CLK);
        RESETn = 1'b1;
        repeat (7) @(negedge CLK);
        check("midfill_ready_a", 32'(ready_a), 32'h0);
        RESETn = 1'b0;
        #1;
        check("midrst_ready_a", 32'(ready_a), 32'h0);

        run_fill();

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'(15 - i), 32'h0, 32'h0);
        end
        idle(3);

        check("queue_a_drained", 32'(exp_a_q.size()), 32'h0);
        check("queue_b_drained", 32'(exp_b_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
